// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV32M/RV64M multiply/divide unit. Accepts one
//                operation over a valid/ready handshake, iterates
//                BITS_PER_CYCLE bits per cycle on operand magnitudes
//                (shift-add multiply, restoring divide), then sign-corrects
//                and holds the result until the consumer takes it.
//  Ports       : clk_i, rst_i (async, active-high)
//                valid_i / ready_o   request handshake (ready_o high in IDLE)
//                op_i, in1_i, in2_i  funct3 and operands
//                kill_i              flush, abandons any in-flight operation
//                valid_o / ready_i   result handshake
//                out_o               result
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN           = 32,  // 32 or 64
  parameter int BITS_PER_CYCLE = 1    // 1, 2 or 4; must divide XLEN
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] in1_i,
  input  logic [XLEN-1:0] in2_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] out_o
);

  localparam int              C_STEPS    = XLEN / BITS_PER_CYCLE;
  localparam int              C_CNT_W    = $clog2(C_STEPS);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_STEPS - 1);
  localparam logic [XLEN-1:0] C_MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] C_ALL_ONES = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d;      // multiplicand magnitude
  logic [XLEN-1:0]     b_q, b_d;      // divisor magnitude
  logic [XLEN-1:0]     hi_q, hi_d;    // product high half / partial remainder
  logic [XLEN-1:0]     lo_q, lo_d;    // multiplier -> product low / dividend -> quotient
  logic [C_CNT_W-1:0]  cnt_q, cnt_d;
  logic                neg_q, neg_d;  // negate the magnitude result at the end
  logic [XLEN-1:0]     out_q, out_d;
  logic                valid_q, valid_d;

  // --------------------------------------------------------------------------
  // Accept-time decode: operand signedness, magnitudes and divide special cases
  // --------------------------------------------------------------------------
  logic            w_is_div, w_s1, w_s2, w_div_zero, w_div_ovf;
  logic [XLEN-1:0] w_in1_mag, w_in2_mag;

  always_comb begin
    w_is_div = op_i[2];
    if (w_is_div) begin
      // DIV/REM are signed (op_i[0]==0), DIVU/REMU unsigned
      w_s1 = ~op_i[0] & in1_i[XLEN-1];
      w_s2 = ~op_i[0] & in2_i[XLEN-1];
    end else begin
      // MUL keeps only the low half, which is sign-agnostic: treat as unsigned
      w_s1 = ((op_i[1:0] == 2'b01) || (op_i[1:0] == 2'b10)) && in1_i[XLEN-1];
      w_s2 = (op_i[1:0] == 2'b01) && in2_i[XLEN-1];
    end
    w_in1_mag  = w_s1 ? -in1_i : in1_i;
    w_in2_mag  = w_s2 ? -in2_i : in2_i;
    w_div_zero = w_is_div && (in2_i == '0);
    w_div_ovf  = w_is_div && !op_i[0] && (in1_i == C_MIN_INT) && (in2_i == C_ALL_ONES);
  end

  // --------------------------------------------------------------------------
  // One CALC cycle: BITS_PER_CYCLE radix-2 steps chained combinationally
  // --------------------------------------------------------------------------
  logic [XLEN:0]   w_t;
  logic [XLEN-1:0] w_hi, w_lo;

  always_comb begin
    w_hi = hi_q;
    w_lo = lo_q;
    w_t  = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op_q[2]) begin
        // Restoring divide: shift next dividend bit into the remainder
        w_t  = {w_hi, w_lo[XLEN-1]};
        w_lo = {w_lo[XLEN-2:0], 1'b0};
        if (w_t >= {1'b0, b_q}) begin
          w_t     = w_t - {1'b0, b_q};
          w_lo[0] = 1'b1;
        end
        w_hi = w_t[XLEN-1:0];  // remainder < divisor, so it fits XLEN bits
      end else begin
        // Shift-add multiply: conditional add then shift {carry,hi,lo} right
        w_t  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, a_q} : '0);
        w_lo = {w_t[0], w_lo[XLEN-1:1]};
        w_hi = w_t[XLEN:1];
      end
    end
  end

  // Sign correction of the completed magnitude result
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_raw, w_res;

  always_comb begin
    w_prod = {w_hi, w_lo};
    if (neg_q) begin
      w_prod = -w_prod;
    end
    w_raw = op_q[1] ? w_hi : w_lo;  // remainder : quotient
    if (op_q[2]) begin
      w_res = neg_q ? -w_raw : w_raw;
    end else begin
      w_res = (op_q[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    out_d   = out_q;
    valid_d = valid_q;

    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          op_d  = op_i;
          cnt_d = '0;
          // Remainder takes the dividend's sign; everything else the xor
          neg_d = (w_is_div && op_i[1]) ? w_s1 : (w_s1 ^ w_s2);
          if (w_div_zero) begin
            out_d   = op_i[1] ? in1_i : C_ALL_ONES;
            valid_d = 1'b1;
            state_d = S_DONE;
          end else if (w_div_ovf) begin
            out_d   = op_i[1] ? '0 : in1_i;
            valid_d = 1'b1;
            state_d = S_DONE;
          end else begin
            a_d     = w_in1_mag;
            b_d     = w_in2_mag;
            hi_d    = '0;
            lo_d    = w_is_div ? w_in1_mag : w_in2_mag;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        hi_d  = w_hi;
        lo_d  = w_lo;
        cnt_d = cnt_q + C_CNT_W'(1);
        if (cnt_q == C_CNT_LAST) begin
          out_d   = w_res;
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Flush wins over everything; out_o deliberately keeps its last value
    if (kill_i) begin
      valid_d = 1'b0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign ready_o = (state_q == S_IDLE);
  assign valid_o = valid_q;
  assign out_o   = out_q;

endmodule
`default_nettype wire
